// File: rtl/swipt_pkg.sv
// swipt_pkg: shared types and constants for the SWIPT session controller.
//   FREQ_W   width of PWM frequency words
//   ENV_W    width of the averaged envelope and its thresholds
//   state_t  session state encoding exposed on o_state
//   FLT_*    latched fault codes exposed on o_fault
package swipt_pkg;
    localparam int FREQ_W = 32;
    localparam int ENV_W = 12;
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PING  = 3'd1,
        ST_TRACK = 3'd2,
        ST_RUN   = 3'd3,
        ST_FAULT = 3'd4,
        ST_COOL  = 3'd5
    } state_t;
    localparam logic [1:0] FLT_NONE = 2'd0;
    localparam logic [1:0] FLT_OV   = 2'd1;
    localparam logic [1:0] FLT_HB   = 2'd2;
endpackage

// File: rtl/swipt_persist_cnt.sv
// swipt_persist_cnt: consecutive-condition qualifier.
//   clk, nrst   clock, synchronous active-low reset
//   cond        condition to qualify; any low cycle restarts the count
//   clr         restart the count (state change)
//   threshold   number of consecutive cond cycles required
//   expired     high in the cycle the threshold-th consecutive cond is seen
module swipt_persist_cnt #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             cond,
    input  logic             clr,
    input  logic [CNT_W-1:0] threshold,
    output logic             expired
);
    logic [CNT_W-1:0] cnt;

    // Saturates at threshold so a long-held condition never wraps back to zero.
    always_ff @(posedge clk) begin
        if (!nrst || clr || !cond) cnt <= '0;
        else if (cnt != threshold) cnt <= cnt + CNT_W'(1);
    end

    assign expired = cond && (cnt >= threshold - CNT_W'(1));
endmodule

// File: rtl/swipt_session_ctrl.sv
// swipt_session_ctrl: session sequencer deciding when and at which frequency the SWIPT bridge switches.
//   clk, nrst     clock, synchronous active-low reset
//   i_arm         software enable; low stops the session and clears FAULT
//   i_alive       heartbeat-watchdog alive flag
//   i_ping_freq   PWM frequency word used while pinging
//   i_env_min     receiver-present threshold on the averaged envelope
//   i_env_max     overvoltage threshold on the averaged envelope
//   i_envelope    boxcar-averaged ADC envelope
//   i_trk_freq    frequency word from the tracker
//   i_trk_enable  tracker output-valid flag
//   o_trk_start   one-cycle pulse restarting the tracker search
//   o_pwm_enable  PWM bridge enable
//   o_pwm_freq    frequency word to the PWM
//   o_state       current session state
//   o_fault       latched fault code
module swipt_session_ctrl
    import swipt_pkg::*;
#(
    parameter int PING_CYCLES   = 100000,
    parameter int LOCK_CYCLES   = 50000,
    parameter int TRACK_TIMEOUT = 2000000,
    parameter int OV_CYCLES     = 1000,
    parameter int LOSS_CYCLES   = 20000,
    parameter int COOL_CYCLES   = 5000000,
    parameter int CNT_W         = 24
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              i_arm,
    input  logic              i_alive,
    input  logic [FREQ_W-1:0] i_ping_freq,
    input  logic [ENV_W-1:0]  i_env_min,
    input  logic [ENV_W-1:0]  i_env_max,
    input  logic [ENV_W-1:0]  i_envelope,
    input  logic [FREQ_W-1:0] i_trk_freq,
    input  logic              i_trk_enable,
    output logic              o_trk_start,
    output logic              o_pwm_enable,
    output logic [FREQ_W-1:0] o_pwm_freq,
    output logic [2:0]        o_state,
    output logic [1:0]        o_fault
);
    localparam logic [CNT_W-1:0] PING_END  = CNT_W'(PING_CYCLES - 1);
    localparam logic [CNT_W-1:0] TRACK_END = CNT_W'(TRACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] COOL_END  = CNT_W'(COOL_CYCLES - 1);

    state_t            state, state_d;
    logic [CNT_W-1:0]  timer;
    logic [1:0]        fault_d;
    logic              pwm_d, start_d;
    logic [FREQ_W-1:0] freq_d;
    logic              chg, lock_exp, ov_exp, loss_exp;

    assign chg = state_d != state;
    assign o_state = state;

    swipt_persist_cnt #(.CNT_W(CNT_W)) u_lock (
        .clk(clk), .nrst(nrst),
        .cond(state == ST_TRACK && i_trk_enable),
        .clr(chg), .threshold(CNT_W'(LOCK_CYCLES)), .expired(lock_exp)
    );

    swipt_persist_cnt #(.CNT_W(CNT_W)) u_ov (
        .clk(clk), .nrst(nrst),
        .cond(state inside {ST_PING, ST_TRACK, ST_RUN} && i_envelope > i_env_max),
        .clr(chg), .threshold(CNT_W'(OV_CYCLES)), .expired(ov_exp)
    );

    swipt_persist_cnt #(.CNT_W(CNT_W)) u_loss (
        .clk(clk), .nrst(nrst),
        .cond(state == ST_RUN && i_envelope < i_env_min),
        .clr(chg), .threshold(CNT_W'(LOSS_CYCLES)), .expired(loss_exp)
    );

    // Outputs are registered alongside the state so they change in the same cycle as o_state.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state        <= ST_IDLE;
            timer        <= '0;
            o_fault      <= FLT_NONE;
            o_pwm_enable <= 1'b0;
            o_pwm_freq   <= '0;
            o_trk_start  <= 1'b0;
        end else begin
            state        <= state_d;
            timer        <= chg ? '0 : (timer != '1) ? timer + CNT_W'(1) : timer;
            o_fault      <= fault_d;
            o_pwm_enable <= pwm_d;
            o_pwm_freq   <= freq_d;
            o_trk_start  <= start_d;
        end
    end

    always_comb begin
        state_d = state;
        fault_d = o_fault;
        case (state)
            ST_IDLE:  if (i_arm && i_alive) state_d = ST_PING;
            ST_PING:  if (timer == PING_END) state_d = (i_envelope >= i_env_min) ? ST_TRACK : ST_COOL;
            ST_TRACK: if (lock_exp) state_d = ST_RUN;
                      else if (timer == TRACK_END) state_d = ST_COOL;
            ST_RUN:   if (loss_exp) state_d = ST_COOL;
            ST_COOL:  if (timer == COOL_END) state_d = ST_IDLE;
            ST_FAULT: if (!i_arm) begin
                          state_d = ST_IDLE;
                          fault_d = FLT_NONE;
                      end
            default:  begin
                          state_d = ST_FAULT;
                          fault_d = FLT_HB;
                      end
        endcase
        // Session overrides: heartbeat loss beats disarm beats overvoltage; OV also beats loss.
        if (state inside {ST_PING, ST_TRACK, ST_RUN, ST_COOL}) begin
            if (!i_alive) begin
                state_d = ST_FAULT;
                fault_d = FLT_HB;
            end else if (!i_arm) begin
                state_d = ST_IDLE;
            end else if (ov_exp) begin
                state_d = ST_FAULT;
                fault_d = FLT_OV;
            end
        end
    end

    always_comb begin
        pwm_d   = state_d inside {ST_PING, ST_RUN} || (state_d == ST_TRACK && i_trk_enable);
        freq_d  = (state_d == ST_PING) ? i_ping_freq :
                  (state_d inside {ST_TRACK, ST_RUN}) ? i_trk_freq : '0;
        start_d = state_d == ST_TRACK && state != ST_TRACK;
    end
endmodule

// File: tb/tb_swipt_session_ctrl.sv
// tb_swipt_session_ctrl: scoreboard bench for swipt_session_ctrl with scaled timers
module tb_swipt_session_ctrl;
  import swipt_pkg::*;
  localparam logic [31:0] PF = 32'h1000_0000;
  localparam logic [31:0] TF = 32'h2000_0000;
  localparam logic [31:0] F0 = 32'h0;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        arm = 1'b0;
  logic        alive = 1'b1;
  logic        trk_en = 1'b1;
  logic [11:0] env_min = 12'd500;
  logic [11:0] env_max = 12'd3000;
  logic [11:0] env = 12'd800;
  logic        trk_start, pwm_enable;
  logic [31:0] pwm_freq;
  logic [2:0]  state;
  logic [1:0]  fault;
  swipt_session_ctrl #(
    .PING_CYCLES(10), .LOCK_CYCLES(8), .TRACK_TIMEOUT(50),
    .OV_CYCLES(4), .LOSS_CYCLES(6), .COOL_CYCLES(20), .CNT_W(24)
  ) dut (
    .clk(clk), .nrst(nrst), .i_arm(arm), .i_alive(alive),
    .i_ping_freq(PF), .i_env_min(env_min), .i_env_max(env_max),
    .i_envelope(env), .i_trk_freq(TF), .i_trk_enable(trk_en),
    .o_trk_start(trk_start), .o_pwm_enable(pwm_enable), .o_pwm_freq(pwm_freq),
    .o_state(state), .o_fault(fault)
  );
  typedef struct {
    int          cyc;
    string       name;
    logic [2:0]  st;
    logic        pwm;
    logic [31:0] freq;
    logic        start;
    logic [1:0]  flt;
  } exp_t;
  exp_t q[$];
  int   cycle = 0;
  int   checks = 0;
  int   errors = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;
  always @(negedge clk) begin
    exp_t e;
    while (q.size() > 0 && q[0].cyc <= cycle) begin
      e = q.pop_front();
      checks++;
      if ({state, pwm_enable, pwm_freq, trk_start, fault} !== {e.st, e.pwm, e.freq, e.start, e.flt}) begin
        errors++;
        $display("FAIL %s: got state=%0d pwm=%b freq=%h start=%b fault=%0d, want state=%0d pwm=%b freq=%h start=%b fault=%0d",
                 e.name, state, pwm_enable, pwm_freq, trk_start, fault, e.st, e.pwm, e.freq, e.start, e.flt);
      end
    end
  end
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input state_t s, input logic p, input logic [31:0] f,
                     input logic st, input logic [1:0] fl);
    exp_t e;
    e.cyc = cycle;
    e.name = n;
    e.st = s;
    e.pwm = p;
    e.freq = f;
    e.start = st;
    e.flt = fl;
    q.push_back(e);
  endtask
  task automatic to_run();
    step(1);
    step(10);
    step(8);
  endtask
  initial begin
    step(2);
    checks++;
    if ({state, pwm_enable, pwm_freq, trk_start, fault} !== {3'(ST_IDLE), 1'b0, F0, 1'b0, FLT_NONE}) begin
      errors++;
      $display("FAIL reset_now: got state=%0d pwm=%b freq=%h start=%b fault=%0d",
               state, pwm_enable, pwm_freq, trk_start, fault);
    end
    chk("reset", ST_IDLE, 1'b0, F0, 1'b0, FLT_NONE);
    nrst = 1'b1; arm = 1'b1;
    step(1); chk("t1_ping_entry", ST_PING, 1'b1, PF, 1'b0, FLT_NONE);
    step(9); chk("t1_ping_last", ST_PING, 1'b1, PF, 1'b0, FLT_NONE);
    step(1); chk("t1_track_start", ST_TRACK, 1'b1, TF, 1'b1, FLT_NONE);
    step(1); chk("t1_start_once", ST_TRACK, 1'b1, TF, 1'b0, FLT_NONE);
    step(6); chk("t1_track_8th", ST_TRACK, 1'b1, TF, 1'b0, FLT_NONE);
    step(1); chk("t1_run", ST_RUN, 1'b1, TF, 1'b0, FLT_NONE);
    env = 12'd3500; step(3); chk("t3_ov3_run", ST_RUN, 1'b1, TF, 1'b0, FLT_NONE);
    env = 12'd800;  step(1); chk("t3_dip_run", ST_RUN, 1'b1, TF, 1'b0, FLT_NONE);
    env = 12'd3500; step(3); chk("t3_ov_pre", ST_RUN, 1'b1, TF, 1'b0, FLT_NONE);
    step(1); chk("t3_ov_fault", ST_FAULT, 1'b0, F0, 1'b0, FLT_OV);
    step(5); chk("t3_fault_held", ST_FAULT, 1'b0, F0, 1'b0, FLT_OV);
    arm = 1'b0; step(1); chk("t3_fault_clr", ST_IDLE, 1'b0, F0, 1'b0, FLT_NONE);
    env = 12'd100; arm = 1'b1;
    step(1);  chk("t2_ping", ST_PING, 1'b1, PF, 1'b0, FLT_NONE);
    step(9);  chk("t2_ping_last", ST_PING, 1'b1, PF, 1'b0, FLT_NONE);
    step(1);  chk("t2_cool", ST_COOL, 1'b0, F0, 1'b0, FLT_NONE);
    step(19); chk("t2_cool_last", ST_COOL, 1'b0, F0, 1'b0, FLT_NONE);
    step(1);  chk("t2_idle", ST_IDLE, 1'b0, F0, 1'b0, FLT_NONE);
    step(1);  chk("t2_reping", ST_PING, 1'b1, PF, 1'b0, FLT_NONE);
    env = 12'd800;
    step(10); chk("t5_track", ST_TRACK, 1'b1, TF, 1'b1, FLT_NONE);
    for (int i = 0; i < 50; i++) begin
      trk_en = ((i / 5) % 2) == 0;
      step(1);
      if (i < 49) chk("t5_toggle", ST_TRACK, trk_en, TF, 1'b0, FLT_NONE);
      else chk("t5_timeout_cool", ST_COOL, 1'b0, F0, 1'b0, FLT_NONE);
    end
    checks++;
    if (state !== 3'(ST_COOL) || pwm_enable !== 1'b0) begin
      errors++;
      $display("FAIL t5_timeout_now: got state=%0d pwm=%b, want state=%0d pwm=0", state, pwm_enable, ST_COOL);
    end
    arm = 1'b0; trk_en = 1'b1;
    step(1); chk("t4_cool_disarm", ST_IDLE, 1'b0, F0, 1'b0, FLT_NONE);
    arm = 1'b1;
    step(11); chk("t4_track", ST_TRACK, 1'b1, TF, 1'b1, FLT_NONE);
    step(2); alive = 1'b0;
    step(1); chk("t4_hb_track", ST_FAULT, 1'b0, F0, 1'b0, FLT_HB);
    alive = 1'b1;
    step(2); chk("t4_hb_held", ST_FAULT, 1'b0, F0, 1'b0, FLT_HB);
    arm = 1'b0;
    step(1); chk("t4_hb_clr", ST_IDLE, 1'b0, F0, 1'b0, FLT_NONE);
    arm = 1'b1;
    to_run(); chk("t4_run", ST_RUN, 1'b1, TF, 1'b0, FLT_NONE);
    alive = 1'b0; arm = 1'b0;
    step(1); chk("t4_hb_over_disarm", ST_FAULT, 1'b0, F0, 1'b0, FLT_HB);
    alive = 1'b1;
    step(1); chk("t4_hb_run_clr", ST_IDLE, 1'b0, F0, 1'b0, FLT_NONE);
    arm = 1'b1;
    to_run(); chk("t6_run", ST_RUN, 1'b1, TF, 1'b0, FLT_NONE);
    nrst = 1'b0;
    step(1); chk("t6_reset", ST_IDLE, 1'b0, F0, 1'b0, FLT_NONE);
    nrst = 1'b1; env = 12'd500;
    step(1);  chk("t6_ping", ST_PING, 1'b1, PF, 1'b0, FLT_NONE);
    step(10); chk("t6_env_eq_min_track", ST_TRACK, 1'b1, TF, 1'b1, FLT_NONE);
    step(8);  chk("t6_run2", ST_RUN, 1'b1, TF, 1'b0, FLT_NONE);
    env = 12'd100;
    step(5); chk("t6_loss5_run", ST_RUN, 1'b1, TF, 1'b0, FLT_NONE);
    step(1); chk("t6_loss_cool", ST_COOL, 1'b0, F0, 1'b0, FLT_NONE);
    arm = 1'b0;
    step(1); chk("b_idle", ST_IDLE, 1'b0, F0, 1'b0, FLT_NONE);
    arm = 1'b1; env = 12'd800;
    to_run(); chk("b_run", ST_RUN, 1'b1, TF, 1'b0, FLT_NONE);
    env = 12'd3000;
    step(6); chk("b_env_eq_max_run", ST_RUN, 1'b1, TF, 1'b0, FLT_NONE);
    env_min = 12'd3000; env_max = 12'd500; env = 12'd800;
    step(3); chk("b_cfg_err_pre", ST_RUN, 1'b1, TF, 1'b0, FLT_NONE);
    step(1); chk("b_cfg_err_ov", ST_FAULT, 1'b0, F0, 1'b0, FLT_OV);
    repeat (2) @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
